// File: rtl/mem_stage_if.sv
// Data-memory port between the MEM stage and the data memory.
// Request fields are held stable from req rise until ack or abort.
// Memory completes with a one-cycle ack; there is no other backpressure.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: load/store access over req/ack, load extension, MEM/WB register.
// Latency: 1 IDLE cycle + N BUSY cycles to ack; result on wb_* one edge after ack.
// Backpressure: o_stall holds EX/MEM while an access is pending; timeout aborts.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_reg_write_in,
  input  logic        i_mem_to_reg_in,
  input  logic        i_mem_read_in,
  input  logic        i_mem_write_in,
  input  logic [31:0] i_alu_result_in,
  input  logic [31:0] i_rs2_data_in,
  input  logic [4:0]  i_rd_in,
  input  logic [2:0]  i_funct3_in,
  mem_stage_if.master dmem,
  output logic        o_stall,
  output logic        o_wb_reg_write,
  output logic        o_wb_mem_to_reg,
  output logic [31:0] o_wb_mem_data,
  output logic [31:0] o_wb_alu_result,
  output logic [4:0]  o_wb_rd,
  output logic        o_wb_misaligned,
  output logic        o_wb_bus_error
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt;

  // Fields latched at BUSY entry and held for the whole access.
  logic        r_we, r_reg_write, r_mem_to_reg;
  logic [31:0] r_alu, r_wdata;
  logic [3:0]  r_be;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;

  // MEM/WB pipeline register.
  logic        r_wb_reg_write, r_wb_mem_to_reg, r_wb_misaligned, r_wb_bus_error;
  logic [31:0] r_wb_mem_data, r_wb_alu_result;
  logic [4:0]  r_wb_rd;

  logic        w_mem_op, w_is_b, w_is_h, w_misal, w_busy, w_timeout, w_stall, w_latch;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;
  logic        w_wb_reg_write, w_wb_mem_to_reg, w_wb_misaligned, w_wb_bus_error;
  logic [31:0] w_wb_mem_data, w_wb_alu_result;
  logic [4:0]  w_wb_rd;

  // funct3[1:0] gives the size (00 byte, 01 half, else word); funct3[2] means unsigned.
  assign w_mem_op  = i_mem_read_in | i_mem_write_in;
  assign w_is_b    = (i_funct3_in[1:0] == 2'b00);
  assign w_is_h    = (i_funct3_in[1:0] == 2'b01);
  assign w_misal   = w_mem_op & (w_is_h ? i_alu_result_in[0]
                                        : (~w_is_b & (|i_alu_result_in[1:0])));
  assign w_busy    = (r_state == S_BUSY);
  assign w_timeout = w_busy && (TIMEOUT_CYCLES != 0) && (r_cnt == 32'(TIMEOUT_CYCLES));

  // Store lane formatting; loads always read the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_rs2_data_in;
    if (i_mem_write_in) begin
      if (w_is_b) begin
        w_be    = 4'b0001 << i_alu_result_in[1:0];
        w_wdata = {4{i_rs2_data_in[7:0]}};
      end else if (w_is_h) begin
        w_be    = i_alu_result_in[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_rs2_data_in[15:0]}};
      end
    end
  end

  // Load lane select and sign/zero extension from the latched address and size.
  always_comb begin
    w_ld_byte = dmem.dmem_rdata[7:0];
    case (r_alu[1:0])
      2'd1:    w_ld_byte = dmem.dmem_rdata[15:8];
      2'd2:    w_ld_byte = dmem.dmem_rdata[23:16];
      2'd3:    w_ld_byte = dmem.dmem_rdata[31:24];
      default: w_ld_byte = dmem.dmem_rdata[7:0];
    endcase
    w_ld_half = r_alu[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    if (r_f3[1:0] == 2'b00)
      w_ld_data = {{24{~r_f3[2] & w_ld_byte[7]}}, w_ld_byte};
    else if (r_f3[1:0] == 2'b01)
      w_ld_data = {{16{~r_f3[2] & w_ld_half[15]}}, w_ld_half};
    else
      w_ld_data = dmem.dmem_rdata;
    if (r_we)
      w_ld_data = 32'd0;
  end

  // Next state, stall and MEM/WB next value; a bubble is the default.
  always_comb begin
    w_state_nxt     = r_state;
    w_stall         = 1'b0;
    w_latch         = 1'b0;
    w_wb_reg_write  = 1'b0;
    w_wb_mem_to_reg = 1'b0;
    w_wb_mem_data   = 32'd0;
    w_wb_alu_result = 32'd0;
    w_wb_rd         = 5'd0;
    w_wb_misaligned = 1'b0;
    w_wb_bus_error  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op && !w_misal) begin
          w_stall     = 1'b1;
          w_latch     = 1'b1;
          w_state_nxt = S_BUSY;
        end else if (w_mem_op) begin
          w_wb_rd         = i_rd_in;
          w_wb_alu_result = i_alu_result_in;
          w_wb_misaligned = 1'b1;
        end else begin
          w_wb_reg_write  = i_reg_write_in;
          w_wb_mem_to_reg = i_mem_to_reg_in;
          w_wb_rd         = i_rd_in;
          w_wb_alu_result = i_alu_result_in;
        end
      end
      S_BUSY: begin
        if (dmem.dmem_ack) begin
          w_state_nxt     = S_IDLE;
          w_wb_reg_write  = r_reg_write;
          w_wb_mem_to_reg = r_mem_to_reg;
          w_wb_rd         = r_rd;
          w_wb_alu_result = r_alu;
          w_wb_mem_data   = w_ld_data;
        end else if (w_timeout) begin
          w_state_nxt    = S_IDLE;
          w_wb_bus_error = 1'b1;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_stall          = w_stall & ~reset;
  assign dmem.dmem_req    = w_busy & ~w_timeout;
  assign dmem.dmem_we     = r_we;
  assign dmem.dmem_addr   = {r_alu[31:2], 2'b00};
  assign dmem.dmem_wdata  = r_wdata;
  assign dmem.dmem_be     = r_be;

  assign o_wb_reg_write   = r_wb_reg_write;
  assign o_wb_mem_to_reg  = r_wb_mem_to_reg;
  assign o_wb_mem_data    = r_wb_mem_data;
  assign o_wb_alu_result  = r_wb_alu_result;
  assign o_wb_rd          = r_wb_rd;
  assign o_wb_misaligned  = r_wb_misaligned;
  assign o_wb_bus_error   = r_wb_bus_error;

  // State register and BUSY cycle counter, cleared on each BUSY entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch)
        r_cnt <= 32'd0;
      else if (w_busy)
        r_cnt <= r_cnt + 32'd1;
    end
  end

  // Capture the access fields when an aligned memory op starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we         <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu        <= 32'd0;
      r_wdata      <= 32'd0;
      r_be         <= 4'd0;
      r_f3         <= 3'd0;
      r_rd         <= 5'd0;
    end else if (w_latch) begin
      r_we         <= i_mem_write_in;
      r_reg_write  <= i_reg_write_in;
      r_mem_to_reg <= i_mem_to_reg_in;
      r_alu        <= i_alu_result_in;
      r_wdata      <= w_wdata;
      r_be         <= w_be;
      r_f3         <= i_funct3_in;
      r_rd         <= i_rd_in;
    end
  end

  // MEM/WB register loads every edge (bubble, passthrough, fault or load result).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_mem_data   <= 32'd0;
      r_wb_alu_result <= 32'd0;
      r_wb_rd         <= 5'd0;
      r_wb_misaligned <= 1'b0;
      r_wb_bus_error  <= 1'b0;
    end else begin
      r_wb_reg_write  <= w_wb_reg_write;
      r_wb_mem_to_reg <= w_wb_mem_to_reg;
      r_wb_mem_data   <= w_wb_mem_data;
      r_wb_alu_result <= w_wb_alu_result;
      r_wb_rd         <= w_wb_rd;
      r_wb_misaligned <= w_wb_misaligned;
      r_wb_bus_error  <= w_wb_bus_error;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, loads, stores, extension, faults, back-to-back.
// Bench drives the EX/MEM inputs and plays the data memory.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mem_stage;
  logic        clk;
  logic        reset;
  logic        reg_write, mem_to_reg, mem_read, mem_write;
  logic [31:0] alu_result, rs2_data;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        stall, wb_reg_write, wb_mem_to_reg, wb_misaligned, wb_bus_error;
  logic [31:0] wb_mem_data, wb_alu_result;
  logic [4:0]  wb_rd;

  int errs = 0;
  int checks = 0;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_reg_write_in  (reg_write),
    .i_mem_to_reg_in (mem_to_reg),
    .i_mem_read_in   (mem_read),
    .i_mem_write_in  (mem_write),
    .i_alu_result_in (alu_result),
    .i_rs2_data_in   (rs2_data),
    .i_rd_in         (rd),
    .i_funct3_in     (funct3),
    .dmem            (bus),
    .o_stall         (stall),
    .o_wb_reg_write  (wb_reg_write),
    .o_wb_mem_to_reg (wb_mem_to_reg),
    .o_wb_mem_data   (wb_mem_data),
    .o_wb_alu_result (wb_alu_result),
    .o_wb_rd         (wb_rd),
    .o_wb_misaligned (wb_misaligned),
    .o_wb_bus_error  (wb_bus_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd_op, input logic wr_op, input logic rw, input logic m2r,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rdi, input logic [2:0] f3);
    mem_read   = rd_op;
    mem_write  = wr_op;
    reg_write  = rw;
    mem_to_reg = m2r;
    alu_result = addr;
    rs2_data   = data;
    rd         = rdi;
    funct3     = f3;
  endtask

  task automatic set_nop;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 3'd0);
  endtask

  // Memory model: acks in the busy_n-th request cycle. Starts in the IDLE cycle of
  // an op already driven; returns 1 time unit after the ack edge with ack low.
  task automatic run_access(input int busy_n, input logic [31:0] rdata,
                            output int n_stall, output int n_req, output bit done);
    n_stall = 0;
    n_req   = 0;
    done    = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (bus.dmem_req && n_req == busy_n - 1) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
        #1;
        done = 1'b1;
      end
      if (stall) n_stall++;
      if (bus.dmem_req) n_req++;
      step;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 32'd0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = 32'd0;
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'd0, 5'd3, 3'b010);
    step;
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (bus.dmem_req !== 1'b0) begin errs++; $display("FAIL reset_req got %b want 0", bus.dmem_req); end
    checks++;
    if ({bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.dmem_be} !== 69'd0) begin
      errs++; $display("FAIL reset_bus we=%b addr=%h wdata=%h be=%b want all 0",
                       bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.dmem_be);
    end
    checks++;
    if ({wb_reg_write, wb_mem_to_reg, wb_mem_data, wb_alu_result, wb_rd, wb_misaligned, wb_bus_error} !== 73'd0) begin
      errs++; $display("FAIL reset_wb rw=%b m2r=%b data=%h alu=%h rd=%0d mis=%b berr=%b want all 0",
                       wb_reg_write, wb_mem_to_reg, wb_mem_data, wb_alu_result, wb_rd, wb_misaligned, wb_bus_error);
    end
    set_nop;
    step;
    reset = 1'b0;
    step;
  endtask

  task automatic test_passthrough;
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'd0, 5'd10, 3'd0);
    bus.dmem_ack = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL pass_stall got %b want 0", stall); end
    step;
    bus.dmem_ack = 1'b0;
    checks++;
    if ({wb_reg_write, wb_mem_to_reg, wb_rd, wb_alu_result, wb_mem_data} !== {1'b1, 1'b0, 5'd10, 32'hCAFEF00D, 32'd0}) begin
      errs++; $display("FAIL pass_wb rw=%b m2r=%b rd=%0d alu=%h data=%h want 1 0 10 cafef00d 0",
                       wb_reg_write, wb_mem_to_reg, wb_rd, wb_alu_result, wb_mem_data);
    end
    checks++; if (bus.dmem_req !== 1'b0) begin errs++; $display("FAIL pass_idle_ack_req got %b want 0", bus.dmem_req); end
    set_nop;
  endtask

  task automatic test_lw;
    int ns, nr;
    bit ok;
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'd0, 5'd5, 3'b010);
    #1;
    checks++; if (stall !== 1'b1) begin errs++; $display("FAIL lw_idle_stall got %b want 1", stall); end
    run_access(4, 32'hDEADBEEF, ns, nr, ok);
    set_nop;
    checks++; if (ok !== 1'b1) begin errs++; $display("FAIL lw_done got %b want 1 (no request seen)", ok); end
    checks++; if (ns !== 4) begin errs++; $display("FAIL lw_stall_cycles got %0d want 4", ns); end
    checks++; if (nr !== 4) begin errs++; $display("FAIL lw_req_cycles got %0d want 4", nr); end
    checks++;
    if ({wb_reg_write, wb_mem_to_reg, wb_rd, wb_mem_data, wb_alu_result} !== {1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h100}) begin
      errs++; $display("FAIL lw_wb rw=%b m2r=%b rd=%0d data=%h alu=%h want 1 1 5 deadbeef 100",
                       wb_reg_write, wb_mem_to_reg, wb_rd, wb_mem_data, wb_alu_result);
    end
    checks++; if (bus.dmem_req !== 1'b0) begin errs++; $display("FAIL lw_req_after got %b want 0", bus.dmem_req); end
    step;
    checks++; if (wb_reg_write !== 1'b0) begin errs++; $display("FAIL lw_wb_next got rw=%b want 0", wb_reg_write); end
  endtask

  task automatic test_store;
    logic [31:0] a, d, exp_addr, exp_wdata;
    logic [2:0]  f;
    logic [3:0]  exp_be;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin a = 32'h203; d = 32'h000000A5; f = 3'b000; exp_addr = 32'h200; exp_be = 4'b1000; exp_wdata = 32'hA5A5A5A5; end
        1: begin a = 32'h102; d = 32'h1234ABCD; f = 3'b001; exp_addr = 32'h100; exp_be = 4'b1100; exp_wdata = 32'hABCDABCD; end
        default: begin a = 32'h104; d = 32'hCAFEBABE; f = 3'b010; exp_addr = 32'h104; exp_be = 4'b1111; exp_wdata = 32'hCAFEBABE; end
      endcase
      set_op(1'b0, 1'b1, 1'b0, 1'b0, a, d, 5'd0, f);
      #1;
      checks++; if ({stall, bus.dmem_req} !== 2'b10) begin errs++; $display("FAIL st%0d_idle stall=%b req=%b want 1 0", i, stall, bus.dmem_req); end
      step;
      checks++;
      if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata} !== {1'b1, 1'b1, exp_addr, exp_be, exp_wdata}) begin
        errs++; $display("FAIL st%0d_bus req=%b we=%b addr=%h be=%b wdata=%h want 1 1 %h %b %h", i,
                         bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, exp_addr, exp_be, exp_wdata);
      end
      bus.dmem_ack = 1'b1;
      bus.dmem_rdata = 32'hFFFFFFFF;
      #1;
      checks++; if (stall !== 1'b0) begin errs++; $display("FAIL st%0d_ack_stall got %b want 0", i, stall); end
      step;
      bus.dmem_ack = 1'b0;
      set_nop;
      checks++;
      if ({wb_reg_write, wb_mem_data, bus.dmem_req} !== {1'b0, 32'd0, 1'b0}) begin
        errs++; $display("FAIL st%0d_wb rw=%b data=%h req=%b want 0 0 0", i, wb_reg_write, wb_mem_data, bus.dmem_req);
      end
    end
  endtask

  task automatic test_load_ext;
    logic [31:0] a, exp;
    logic [2:0]  f;
    int ns, nr;
    bit ok;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin f = 3'b000; a = 32'h102; exp = 32'hFFFFFF80; end
        1: begin f = 3'b100; a = 32'h102; exp = 32'h00000080; end
        2: begin f = 3'b001; a = 32'h102; exp = 32'h00000080; end
        3: begin f = 3'b001; a = 32'h100; exp = 32'hFFFFFF00; end
        4: begin f = 3'b101; a = 32'h100; exp = 32'h0000FF00; end
        5: begin f = 3'b000; a = 32'h101; exp = 32'hFFFFFFFF; end
        default: begin f = 3'b100; a = 32'h103; exp = 32'h00000000; end
      endcase
      set_op(1'b1, 1'b0, 1'b1, 1'b1, a, 32'd0, 5'd4, f);
      #1;
      run_access(1, 32'h0080FF00, ns, nr, ok);
      set_nop;
      checks++; if (ns !== 1 || !ok) begin errs++; $display("FAIL ld%0d_latency stall=%0d done=%b want 1 1", i, ns, ok); end
      checks++; if (wb_mem_data !== exp) begin errs++; $display("FAIL ld%0d_data got %h want %h", i, wb_mem_data, exp); end
    end
  endtask

  task automatic test_back_to_back;
    int ns, nr;
    bit ok;
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'd0, 5'd1, 3'b010);
    #1;
    run_access(1, 32'h11111111, ns, nr, ok);
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'd0, 5'd2, 3'b010);
    #1;
    checks++;
    if ({wb_mem_data, wb_rd} !== {32'h11111111, 5'd1}) begin
      errs++; $display("FAIL b2b_first data=%h rd=%0d want 11111111 1", wb_mem_data, wb_rd);
    end
    checks++; if ({stall, bus.dmem_req} !== 2'b10) begin errs++; $display("FAIL b2b_gap stall=%b req=%b want 1 0", stall, bus.dmem_req); end
    run_access(1, 32'h22222222, ns, nr, ok);
    set_nop;
    checks++; if (ns !== 1 || nr !== 1 || !ok) begin errs++; $display("FAIL b2b_second_lat stall=%0d req=%0d done=%b want 1 1 1", ns, nr, ok); end
    checks++;
    if ({wb_mem_data, wb_rd, wb_reg_write} !== {32'h22222222, 5'd2, 1'b1}) begin
      errs++; $display("FAIL b2b_second data=%h rd=%0d rw=%b want 22222222 2 1", wb_mem_data, wb_rd, wb_reg_write);
    end
  endtask

  task automatic test_misaligned;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h101, 32'd0, 5'd7, 3'b010);
        1: set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h101, 32'h55, 5'd0, 3'b001);
        default: set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h102, 32'h55, 5'd0, 3'b010);
      endcase
      #1;
      checks++; if ({stall, bus.dmem_req} !== 2'b00) begin errs++; $display("FAIL mis%0d_idle stall=%b req=%b want 0 0", i, stall, bus.dmem_req); end
      step;
      set_nop;
      checks++;
      if ({wb_misaligned, wb_reg_write, wb_mem_to_reg, bus.dmem_req} !== 4'b1000) begin
        errs++; $display("FAIL mis%0d_flag mis=%b rw=%b m2r=%b req=%b want 1 0 0 0", i, wb_misaligned, wb_reg_write, wb_mem_to_reg, bus.dmem_req);
      end
      step;
      checks++; if (wb_misaligned !== 1'b0) begin errs++; $display("FAIL mis%0d_pulse got %b want 0", i, wb_misaligned); end
    end
  endtask

  task automatic test_timeout;
    int nr = 0;
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'd0, 5'd3, 3'b010);
    step;
    for (int c = 0; c < 20; c++) begin
      if (!bus.dmem_req) break;
      nr++;
      step;
    end
    checks++; if (nr !== 4) begin errs++; $display("FAIL to_req_cycles got %0d want 4", nr); end
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL to_stall got %b want 0", stall); end
    step;
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'd0, 5'd9, 3'd0);
    checks++;
    if ({wb_bus_error, wb_reg_write} !== 2'b10) begin
      errs++; $display("FAIL to_flag berr=%b rw=%b want 1 0", wb_bus_error, wb_reg_write);
    end
    step;
    set_nop;
    checks++;
    if ({wb_bus_error, wb_reg_write, wb_rd, wb_alu_result} !== {1'b0, 1'b1, 5'd9, 32'h55}) begin
      errs++; $display("FAIL to_next berr=%b rw=%b rd=%0d alu=%h want 0 1 9 55", wb_bus_error, wb_reg_write, wb_rd, wb_alu_result);
    end
  endtask

  task automatic test_reset_busy;
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'd0, 5'd6, 3'b010);
    step;
    checks++; if (bus.dmem_req !== 1'b1) begin errs++; $display("FAIL rb_req_busy got %b want 1", bus.dmem_req); end
    reset = 1'b1;
    #1;
    checks++; if ({bus.dmem_req, stall} !== 2'b00) begin errs++; $display("FAIL rb_req_drop req=%b stall=%b want 0 0", bus.dmem_req, stall); end
    checks++;
    if ({wb_reg_write, wb_mem_to_reg, wb_mem_data, wb_alu_result, wb_rd, wb_misaligned, wb_bus_error} !== 73'd0) begin
      errs++; $display("FAIL rb_wb rw=%b m2r=%b data=%h alu=%h rd=%0d want all 0",
                       wb_reg_write, wb_mem_to_reg, wb_mem_data, wb_alu_result, wb_rd);
    end
    set_nop;
    step;
    reset = 1'b0;
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'hFFFFFFFF;
    #1;
    checks++; if ({bus.dmem_req, stall} !== 2'b00) begin errs++; $display("FAIL rb_late_ack req=%b stall=%b want 0 0", bus.dmem_req, stall); end
    step;
    bus.dmem_ack = 1'b0;
    checks++;
    if ({wb_reg_write, wb_mem_data, wb_rd} !== {1'b0, 32'd0, 5'd0}) begin
      errs++; $display("FAIL rb_late_wb rw=%b data=%h rd=%0d want 0 0 0", wb_reg_write, wb_mem_data, wb_rd);
    end
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_lw;
    test_store;
    test_load_ext;
    test_back_to_back;
    test_misaligned;
    test_timeout;
    test_reset_busy;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
